buffer_64_to_128: RTL and testbench

//  Packs the 64-bit word stream from buffer_512_to_64 into 128-bit AES blocks.
//  Two consecutive accepted 64-bit words form one block. Blocks are queued in a small FIFO feeding the AES core.

---
 rtl/buffer_64_to_128.sv | 86 ++++++++
 tb/tb_buffer_64_to_128.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/buffer_64_to_128.sv
// Packs pairs of 64-bit words into 128-bit blocks and queues them in a small
// first-word-fall-through FIFO ahead of the AES core.
module buffer_64_to_128 #(
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [63:0]        data_in,
    input  logic               wr_enable,
    output logic               full,
    output logic               full_n,
    output logic [127:0]       data_out,
    input  logic               rd_enable,
    output logic               empty,
    output logic               half,
    output logic [LVL_W-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [63:0]       staging;
    logic              half_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic [127:0]      mem [DEPTH];

    logic wr_en_ok;
    logic rd_ok;
    logic push;

    // A full FIFO only blocks the write that would complete a block; a low
    // word can still be staged while the queue is full.
    assign full     = half_q & (count == LVL_W'(DEPTH));
    assign full_n   = ~full;
    assign empty    = (count == '0);
    assign half     = half_q;
    assign level    = count;
    assign wr_en_ok = wr_enable & ~full;
    assign rd_ok    = rd_enable & ~empty;
    assign push     = wr_en_ok & half_q;
    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging <= '0;
            half_q  <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else if (clr) begin
            half_q  <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (wr_en_ok) begin
                if (!half_q) begin
                    staging <= data_in;
                    half_q  <= 1'b1;
                end else begin
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                    half_q  <= 1'b0;
                end
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, rd_ok})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= {data_in, staging};
        end
    end

endmodule

// File: tb/tb_buffer_64_to_128.sv
// Self-checking bench for buffer_64_to_128: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_buffer_64_to_128;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int ST_W  = LVL_W + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [63:0]      data_in;
    logic             wr_enable;
    logic             full;
    logic             full_n;
    logic [127:0]     data_out;
    logic             rd_enable;
    logic             empty;
    logic             half;
    logic [LVL_W-1:0] level;

    int errors = 0;
    int checks = 0;

    logic [127:0] q[$];
    logic [63:0]  m_stage;
    logic         m_half;

    logic [ST_W-1:0] dut_status;
    assign dut_status = {empty, full, full_n, half, level};

    localparam logic [ST_W-1:0] RESET_STATUS = {1'b1, 1'b0, 1'b1, 1'b0, {LVL_W{1'b0}}};

    buffer_64_to_128 #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .data_in   (data_in),
        .wr_enable (wr_enable),
        .full      (full),
        .full_n    (full_n),
        .data_out  (data_out),
        .rd_enable (rd_enable),
        .empty     (empty),
        .half      (half),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of complete blocks plus one pending low word.
    function automatic logic [127:0] m_head();
        return (q.size() == 0) ? 128'd0 : q[0];
    endfunction

    function automatic logic [ST_W-1:0] m_status();
        logic f;
        f = m_half && (q.size() == DEPTH);
        return {q.size() == 0, f, !f, m_half, LVL_W'(q.size())};
    endfunction

    function automatic logic [127:0] blk(input int hi, input int lo);
        return {64'(hi), 64'(lo)};
    endfunction

    task automatic model_reset();
        q.delete();
        m_stage = '0;
        m_half  = 1'b0;
    endtask

    task automatic step(input logic wr, input logic [63:0] d, input logic rd, input logic c);
        logic pre_full;
        logic pre_empty;
        wr_enable = wr;
        data_in   = d;
        rd_enable = rd;
        clr       = c;
        @(posedge clk);
        pre_full  = m_half && (q.size() == DEPTH);
        pre_empty = (q.size() == 0);
        if (c) begin
            q.delete();
            m_half = 1'b0;
        end else begin
            if (rd && !pre_empty) void'(q.pop_front());
            if (wr && !pre_full) begin
                if (!m_half) begin
                    m_stage = d;
                    m_half  = 1'b1;
                end else begin
                    q.push_back({d, m_stage});
                    m_half = 1'b0;
                end
            end
        end
        #1;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0; data_in = '0;
        model_reset();
        #3;
        checks++; if (dut_status !== RESET_STATUS) begin errors++; $display("[TB] FAIL reset_status: got %b want %b", dut_status, RESET_STATUS); end
        checks++; if (data_out !== 128'd0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", data_out); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 64'hAAAA_0000_0000_0001, 1'b0, 1'b0);
        step(1'b1, 64'hBBBB_0000_0000_0002, 1'b0, 1'b0);
        step(1'b1, 64'hCCCC_0000_0000_0003, 1'b0, 1'b0);
        checks++; if (dut_status !== m_status()) begin errors++; $display("[TB] FAIL pre_rst_status: got %b want %b", dut_status, m_status()); end
        // Asynchronous reset mid-cycle: outputs must drop without a clock edge.
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++; if (dut_status !== RESET_STATUS) begin errors++; $display("[TB] FAIL async_rst_status: got %b want %b", dut_status, RESET_STATUS); end
        checks++; if (data_out !== 128'd0) begin errors++; $display("[TB] FAIL async_rst_data: got %h want 0", data_out); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_pack();
        step(1'b1, 64'd1, 1'b0, 1'b0);
        checks++; if (half !== 1'b1 || empty !== 1'b1) begin errors++; $display("[TB] FAIL pack_half: got half=%b empty=%b want half=1 empty=1", half, empty); end
        step(1'b1, 64'd2, 1'b0, 1'b0);
        checks++; if (data_out !== blk(2, 1)) begin errors++; $display("[TB] FAIL pack_data: got %h want %h", data_out, blk(2, 1)); end
        checks++; if (empty !== 1'b0 || level !== LVL_W'(1)) begin errors++; $display("[TB] FAIL pack_level: got empty=%b level=%0d want empty=0 level=1", empty, level); end
        step(1'b0, 64'd0, 1'b1, 1'b0);
        checks++; if (empty !== 1'b1 || dut_status !== m_status()) begin errors++; $display("[TB] FAIL pack_pop: got %b want %b", dut_status, m_status()); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 9; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
        checks++; if (level !== LVL_W'(4) || half !== 1'b1 || full !== 1'b1 || full_n !== 1'b0) begin errors++; $display("[TB] FAIL fill_full: got level=%0d half=%b full=%b full_n=%b want 4 1 1 0", level, half, full, full_n); end
        step(1'b1, 64'd10, 1'b0, 1'b0);
        checks++; if (dut_status !== m_status() || level !== LVL_W'(4)) begin errors++; $display("[TB] FAIL fill_reject: got %b want %b", dut_status, m_status()); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (data_out !== blk(2 * k, 2 * k - 1)) begin errors++; $display("[TB] FAIL fill_read%0d: got %h want %h", k, data_out, blk(2 * k, 2 * k - 1)); end
            step(1'b0, 64'd0, 1'b1, 1'b0);
        end
        checks++; if (empty !== 1'b1 || half !== 1'b1) begin errors++; $display("[TB] FAIL fill_drained: got empty=%b half=%b want 1 1", empty, half); end
        step(1'b0, 64'd0, 1'b0, 1'b1);
    endtask

    task automatic test_stream();
        int k = 1;
        int n = 0;
        for (int i = 1; i <= 24; i++) begin
            if (!empty) begin
                checks++; if (data_out !== blk(2 * k, 2 * k - 1)) begin errors++; $display("[TB] FAIL stream_blk%0d: got %h want %h", k, data_out, blk(2 * k, 2 * k - 1)); end
                k++;
            end
            step(1'b1, 64'(i), 1'b1, 1'b0);
        end
        while (!empty && n < 20) begin
            checks++; if (data_out !== blk(2 * k, 2 * k - 1)) begin errors++; $display("[TB] FAIL stream_blk%0d: got %h want %h", k, data_out, blk(2 * k, 2 * k - 1)); end
            k++;
            n++;
            step(1'b0, 64'd0, 1'b1, 1'b0);
        end
        checks++; if (k !== 13) begin errors++; $display("[TB] FAIL stream_count: got %0d blocks want 12", k - 1); end
        checks++; if (empty !== 1'b1 || half !== 1'b0) begin errors++; $display("[TB] FAIL stream_end: got empty=%b half=%b want 1 0", empty, half); end
    endtask

    task automatic test_simultaneous();
        step(1'b0, 64'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
        step(1'b1, 64'd6, 1'b1, 1'b0);
        checks++; if (level !== LVL_W'(2) || half !== 1'b0) begin errors++; $display("[TB] FAIL simul_level: got level=%0d half=%b want 2 0", level, half); end
        checks++; if (data_out !== blk(4, 3)) begin errors++; $display("[TB] FAIL simul_head: got %h want %h", data_out, blk(4, 3)); end
        for (int i = 7; i <= 11; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
        checks++; if (full !== 1'b1 || level !== LVL_W'(DEPTH)) begin errors++; $display("[TB] FAIL simul_full: got full=%b level=%0d want 1 %0d", full, level, DEPTH); end
        // A pop in the same cycle must not let the completing write through.
        step(1'b1, 64'd12, 1'b1, 1'b0);
        checks++; if (level !== LVL_W'(DEPTH - 1) || half !== 1'b1) begin errors++; $display("[TB] FAIL simul_reject: got level=%0d half=%b want %0d 1", level, half, DEPTH - 1); end
        checks++; if (data_out !== blk(6, 5) || dut_status !== m_status()) begin errors++; $display("[TB] FAIL simul_head2: got %h want %h", data_out, blk(6, 5)); end
        step(1'b0, 64'd0, 1'b0, 1'b1);
    endtask

    task automatic test_clr();
        step(1'b1, 64'd1, 1'b0, 1'b0);
        step(1'b1, 64'd99, 1'b0, 1'b1);
        checks++; if (half !== 1'b0 || level !== LVL_W'(0) || empty !== 1'b1) begin errors++; $display("[TB] FAIL clr_state: got half=%b level=%0d empty=%b want 0 0 1", half, level, empty); end
        step(1'b1, 64'd5, 1'b0, 1'b0);
        step(1'b1, 64'd6, 1'b0, 1'b0);
        checks++; if (data_out !== blk(6, 5)) begin errors++; $display("[TB] FAIL clr_data: got %h want %h", data_out, blk(6, 5)); end
        step(1'b0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        checks++; if (level !== LVL_W'(0) || empty !== 1'b1 || data_out !== 128'd0) begin errors++; $display("[TB] FAIL clr_underflow: got level=%0d empty=%b data=%h want 0 1 0", level, empty, data_out); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 60, {$urandom, $urandom}, $urandom_range(0, 99) < 40, $urandom_range(0, 99) == 0);
            checks++; if (dut_status !== m_status()) begin errors++; $display("[TB] FAIL rand_status@%0d: got %b want %b", n, dut_status, m_status()); end
            checks++; if (data_out !== m_head()) begin errors++; $display("[TB] FAIL rand_data@%0d: got %h want %h", n, data_out, m_head()); end
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_fill();
        test_stream();
        test_simultaneous();
        test_clr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
